// File: rtl/maj_net_pkg.sv
// Shared types and constants for the time-shared majority-network sweep engine.
package maj_net_pkg;

    localparam int NVARS = 7;
    localparam int SELW  = 4;

    localparam logic [SELW-1:0] SEL_CONST0 = 4'd0;
    localparam logic [SELW-1:0] SEL_X0     = 4'd1;
    localparam logic [SELW-1:0] SEL_W0     = 4'd8;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        DONE
    } state_t;

    typedef struct packed {
        logic            inv;
        logic [SELW-1:0] sel;
    } operand_t;

    // op0 sits in the low bits of the program word
    typedef struct packed {
        operand_t op2;
        operand_t op1;
        operand_t op0;
    } gate_instr_t;

    function automatic logic [3:0] clamp_gates(input logic [3:0] cfg, input int ngates);
        if (cfg == 4'd0) begin
            return 4'd1;
        end
        if (int'(cfg) > ngates) begin
            return 4'(ngates);
        end
        return cfg;
    endfunction

endpackage

// File: rtl/maj3_unit.sv
// Shared combinational datapath: three operand muxes with optional inversion feeding
// one 3-input majority gate.
module maj3_unit
    import maj_net_pkg::*;
#(
    parameter int NGATES = 8,
    parameter int GW     = 3
) (
    input  logic [NVARS-1:0]  vec,
    input  gate_instr_t       instr,
    input  logic [NGATES-1:0] wres,
    input  logic [GW-1:0]     gate_idx,
    output logic              result
);

    // Gate results reachable through the 4-bit select field.
    localparam int WMAX = (NGATES < (1 << SELW) - int'(SEL_W0)) ? NGATES
                                                                : (1 << SELW) - int'(SEL_W0);

    operand_t   ops [3];
    logic [2:0] opv;

    assign ops[0] = instr.op0;
    assign ops[1] = instr.op1;
    assign ops[2] = instr.op2;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_op
            logic raw;

            always_comb begin
                raw = 1'b0;
                if (ops[gi].sel != SEL_CONST0) begin
                    for (int j = 0; j < NVARS; j++) begin
                        if (ops[gi].sel == SELW'(int'(SEL_X0) + j)) begin
                            raw = vec[j];
                        end
                    end
                    // Only gates already evaluated for this vector are visible.
                    for (int j = 0; j < WMAX; j++) begin
                        if (ops[gi].sel == SELW'(int'(SEL_W0) + j) && j < int'(gate_idx)) begin
                            raw = wres[j];
                        end
                    end
                end
            end

            assign opv[gi] = raw ^ ops[gi].inv;
        end
    endgenerate

    assign result = (opv[0] & opv[1]) | (opv[0] & opv[2]) | (opv[1] & opv[2]);

endmodule

// File: rtl/maj_net_sweep_ctrl.sv
// Sweeps all 128 input vectors through a programmable majority network, one gate per
// cycle on a single shared maj3_unit, and publishes the resulting truth table.
module maj_net_sweep_ctrl
    import maj_net_pkg::*;
#(
    parameter int NGATES = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      prog_we,
    input  logic [$clog2(NGATES)-1:0] prog_addr,
    input  logic [14:0]               prog_wdata,
    input  logic [3:0]                cfg_num_gates,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      tt_valid,
    output logic [127:0]              tt_out
);

    localparam int GW = $clog2(NGATES);
    localparam int TT = 2 ** NVARS;

    state_t            state_reg, state_next;
    gate_instr_t       prog_mem [NGATES];
    logic [NGATES-1:0] wreg_reg;
    logic [TT-1:0]     shadow_reg, shadow_next, tt_out_reg;
    logic [NVARS-1:0]  vec_reg;
    logic [GW-1:0]     g_reg;
    logic [3:0]        n_reg;
    logic              tt_valid_reg;
    logic              result, last_gate, last_vec;

    maj3_unit #(
        .NGATES (NGATES),
        .GW     (GW)
    ) u_maj3 (
        .vec      (vec_reg),
        .instr    (prog_mem[g_reg]),
        .wres     (wreg_reg),
        .gate_idx (g_reg),
        .result   (result)
    );

    assign last_gate = (4'(g_reg) == n_reg - 4'd1);
    assign last_vec  = &vec_reg;

    // Final table bit is merged here so tt_out is already complete during the done cycle.
    always_comb begin
        shadow_next          = shadow_reg;
        shadow_next[vec_reg] = result;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = EVAL;
            EVAL:    if (last_gate && last_vec) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            wreg_reg     <= '0;
            shadow_reg   <= '0;
            tt_out_reg   <= '0;
            vec_reg      <= '0;
            g_reg        <= '0;
            n_reg        <= '0;
            tt_valid_reg <= 1'b0;
            for (int i = 0; i < NGATES; i++) begin
                prog_mem[i] <= '0;
            end
        end else begin
            state_reg <= state_next;
            if (prog_we && state_reg == IDLE && int'(prog_addr) < NGATES) begin
                prog_mem[prog_addr] <= gate_instr_t'(prog_wdata);
            end
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        n_reg        <= clamp_gates(cfg_num_gates, NGATES);
                        vec_reg      <= '0;
                        g_reg        <= '0;
                        tt_valid_reg <= 1'b0;
                    end
                end
                EVAL: begin
                    wreg_reg[g_reg] <= result;
                    if (last_gate) begin
                        shadow_reg <= shadow_next;
                        g_reg      <= '0;
                        vec_reg    <= vec_reg + 1'b1;
                        if (last_vec) begin
                            tt_out_reg   <= shadow_next;
                            tt_valid_reg <= 1'b1;
                        end
                    end else begin
                        g_reg <= g_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state_reg != IDLE);
    assign done     = (state_reg == DONE);
    assign tt_valid = tt_valid_reg;
    assign tt_out   = tt_out_reg;

endmodule

// File: tb/tb_maj_net_sweep_ctrl.sv
// Self-checking bench for maj_net_sweep_ctrl: directed and random programs checked
// against a vector-by-vector evaluation of the network.
module tb_maj_net_sweep_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         prog_we = 1'b0;
    logic [2:0]   prog_addr = '0;
    logic [14:0]  prog_wdata = '0;
    logic [3:0]   cfg_num_gates = '0;
    logic         start = 1'b0;
    logic         busy, done, tt_valid;
    logic [127:0] tt_out;

    int           tests = 0;
    int           fails = 0;
    logic [14:0]  mdl_prog [8];
    logic [127:0] mdl_tt = '0;

    always #5 clk = ~clk;

    maj_net_sweep_ctrl #(.NGATES(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .prog_we       (prog_we),
        .prog_addr     (prog_addr),
        .prog_wdata    (prog_wdata),
        .cfg_num_gates (cfg_num_gates),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .tt_valid      (tt_valid),
        .tt_out        (tt_out)
    );

    function automatic int clamp_n(input logic [3:0] cfg);
        if (cfg == 4'd0) return 1;
        if (int'(cfg) > 8) return 8;
        return int'(cfg);
    endfunction

    // Evaluate the programmed network for every input vector.
    function automatic logic [127:0] model_tt(input int n);
        logic [127:0] tt;
        bit           w [8];
        logic [4:0]   opf;
        int           sel, inv, val, cnt;
        tt = '0;
        for (int v = 0; v < 128; v++) begin
            for (int g = 0; g < 8; g++) w[g] = 1'b0;
            for (int g = 0; g < n; g++) begin
                cnt = 0;
                for (int k = 0; k < 3; k++) begin
                    opf = mdl_prog[g][5*k +: 5];
                    sel = int'(opf[3:0]);
                    inv = int'(opf[4]);
                    if (sel == 0) val = 0;
                    else if (sel <= 7) val = (v >> (sel - 1)) & 1;
                    else if (sel - 8 < g) val = int'(w[sel - 8]);
                    else val = 0;
                    cnt += val ^ inv;
                end
                w[g] = (cnt >= 2);
            end
            tt[v] = w[n - 1];
        end
        return tt;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic write_prog(input logic [2:0] a, input logic [14:0] d);
        prog_we    = 1'b1;
        prog_addr  = a;
        prog_wdata = d;
        @(posedge clk);
        #1;
        prog_we       = 1'b0;
        mdl_prog[a]   = d;
    endtask

    // One full sweep from IDLE; returns one cycle after done, back in IDLE.
    task automatic do_sweep(input string tag, input logic [3:0] cfg, input bit disturb,
                            input bit we_start, input logic [14:0] we_data);
        int           n, cycles;
        logic [127:0] exp_tt;
        if (we_start) begin
            prog_we     = 1'b1;
            prog_addr   = 3'd0;
            prog_wdata  = we_data;
            mdl_prog[0] = we_data;
        end
        n      = clamp_n(cfg);
        exp_tt = model_tt(n);
        cfg_num_gates = cfg;
        start         = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        prog_we = 1'b0;
        cycles  = 1;
        check({tag, "_busy_rise"}, 128'(busy), 128'(1));
        check({tag, "_valid_clr"}, 128'(tt_valid), 128'(0));
        check({tag, "_tt_hold"}, tt_out, mdl_tt);
        while (done !== 1'b1 && cycles < 3000) begin
            if (disturb && cycles == 20) begin
                prog_we       = 1'b1;
                prog_addr     = 3'd0;
                prog_wdata    = ~mdl_prog[0];
                start         = 1'b1;
                cfg_num_gates = 4'd8;
            end else begin
                prog_we = 1'b0;
                start   = 1'b0;
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        prog_we = 1'b0;
        start   = 1'b0;
        check({tag, "_latency"}, 128'(cycles), 128'(128 * n + 1));
        check({tag, "_done"}, 128'(done), 128'(1));
        check({tag, "_busy_done"}, 128'(busy), 128'(1));
        check({tag, "_valid"}, 128'(tt_valid), 128'(1));
        check({tag, "_tt"}, tt_out, exp_tt);
        mdl_tt = exp_tt;
        $display("[TB] sweep %s n=%0d cycles=%0d tt=%h", tag, n, cycles, tt_out);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 128'(done), 128'(0));
        check({tag, "_busy_drop"}, 128'(busy), 128'(0));
        check({tag, "_valid_hold"}, 128'(tt_valid), 128'(1));
        check({tag, "_tt_keep"}, tt_out, exp_tt);
    endtask

    initial begin
        logic [127:0] k_e8, k_55, k_f8, k_88;
        k_e8 = {16{8'hE8}};
        k_55 = {16{8'h55}};
        k_f8 = {16{8'hF8}};
        k_88 = {16{8'h88}};
        for (int i = 0; i < 8; i++) mdl_prog[i] = '0;

        #2 rst_n = 1'b0;
        #10;
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_valid", 128'(tt_valid), 128'(0));
        check("rst_tt", tt_out, 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        write_prog(3'd0, {5'd3, 5'd2, 5'd1});
        do_sweep("maj_x012", 4'd1, 1'b0, 1'b0, 15'd0);
        check("maj_x012_const", tt_out, k_e8);
        do_sweep("back_to_back", 4'd1, 1'b0, 1'b0, 15'd0);

        write_prog(3'd0, {5'h10, 5'h00, 5'h11});
        do_sweep("inv_ident", 4'd1, 1'b0, 1'b0, 15'd0);
        check("inv_ident_const", tt_out, k_55);

        write_prog(3'd0, {5'd0, 5'd2, 5'd1});
        write_prog(3'd1, {5'h10, 5'd3, 5'd8});
        do_sweep("two_gate", 4'd2, 1'b0, 1'b0, 15'd0);
        check("two_gate_const", tt_out, k_f8);

        write_prog(3'd0, {5'd2, 5'd1, 5'd9});
        do_sweep("fwd_ref", 4'd1, 1'b0, 1'b0, 15'd0);
        check("fwd_ref_const", tt_out, k_88);

        do_sweep("clamp_zero", 4'd0, 1'b0, 1'b0, 15'd0);
        do_sweep("clamp_max", 4'd15, 1'b0, 1'b0, 15'd0);

        write_prog(3'd0, {5'd3, 5'd2, 5'd1});
        do_sweep("busy_ignore", 4'd1, 1'b1, 1'b0, 15'd0);
        check("busy_ignore_const", tt_out, k_e8);
        do_sweep("mem_unchanged", 4'd1, 1'b0, 1'b0, 15'd0);
        check("mem_unchanged_const", tt_out, k_e8);

        do_sweep("we_with_start", 4'd1, 1'b0, 1'b1, {5'h10, 5'h00, 5'h11});
        check("we_with_start_const", tt_out, k_55);

        for (int i = 0; i < 6; i++) begin
            for (int a = 0; a < 8; a++) begin
                write_prog(3'(a), 15'($urandom));
            end
            do_sweep($sformatf("rand%0d", i), 4'($urandom_range(15, 0)), 1'b0, 1'b0, 15'd0);
        end

        // Asynchronous reset in the middle of a sweep.
        write_prog(3'd0, {5'd3, 5'd2, 5'd1});
        cfg_num_gates = 4'd1;
        start         = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (50) @(posedge clk);
        #2;
        check("mid_busy", 128'(busy), 128'(1));
        rst_n = 1'b0;
        #1;
        check("arst_busy", 128'(busy), 128'(0));
        check("arst_done", 128'(done), 128'(0));
        check("arst_valid", 128'(tt_valid), 128'(0));
        check("arst_tt", tt_out, 128'(0));
        $display("[TB] async reset at eval cycle 50 busy=%0d tt_valid=%0d", busy, tt_valid);
        for (int i = 0; i < 8; i++) mdl_prog[i] = '0;
        mdl_tt = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_sweep("post_reset", 4'd1, 1'b0, 1'b0, 15'd0);
        check("post_reset_zero", tt_out, 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
